pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00, is the value loaded into the PC on reset.
REQ-002 Parameter COUNT_W, default 16, is the width of the retired-instruction counter.
REQ-003 Port clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 Port resetN  input  1  is the synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port pcOut  output  8  is the current PC, driven to the instruction memory and to the sequential adder's firstData.
REQ-006 Port pcNextSeq  input  8  is the sequential-increment adder result, pcOut + 1.
REQ-007 Port branchTarget  input  8  is the branch adder result.
REQ-008 Port branchTaken  input  1  selects branchTarget as the next PC.
REQ-009 Port jump  input  1  selects jumpTarget as the next PC.
REQ-010 Port jumpTarget  input  8  is the absolute jump address.
REQ-011 Port stall  input  1  holds the PC for the current cycle.
REQ-012 Port haltReq  input  1  requests entry to the HALTED state.
REQ-013 Port stepReq  input  1  requests one instruction advance while HALTED.
REQ-014 Port resumeReq  input  1  returns the block from HALTED to RUN.
REQ-015 Port halted  output  1  is high when the state is HALTED.
REQ-016 Port retireCount  output  COUNT_W  is the count of PC advances.
REQ-017 Port wrapFlag  output  1  is a sticky indication that a sequential advance wrapped from 8'hFF to 8'h00.

Function
REQ-018 The FSM SHALL have three states: RUN, HALTED and STEP, all fully registered.
REQ-019 An "advance" SHALL occur in a cycle when the state is RUN or STEP, stall=0, and, in RUN, haltReq=0.
REQ-020 On an advance, the next-PC selection SHALL use this priority: jump → jumpTarget; else branchTaken → branchTarget; else pcNextSeq.
REQ-021 In any cycle without an advance, pcOut SHALL hold its value.
REQ-022 The PC update SHALL have a latency of one cycle: the selected value appears on pcOut on the edge following the advance cycle.
REQ-023 In RUN, haltReq=1 SHALL suppress the advance in that cycle and move the FSM to HALTED, regardless of stall, jump or branchTaken.
REQ-024 In HALTED, resumeReq=1 SHALL move the FSM to RUN; otherwise stepReq=1 SHALL move it to STEP; resumeReq wins when both are asserted.
REQ-025 In HALTED, haltReq SHALL be ignored.
REQ-026 In STEP, the FSM SHALL remain in STEP while stall=1 and SHALL return to HALTED on the edge that completes the single advance.
REQ-027 In STEP, haltReq and stepReq SHALL be ignored.
REQ-028 halted SHALL be 1 only in HALTED; it SHALL be 0 in RUN and STEP.
REQ-029 retireCount SHALL increment by 1 on every advance and SHALL saturate at all-ones.
REQ-030 The PC SHALL wrap naturally modulo 256, with no special handling: pcNextSeq = 8'h00 from 8'hFF loads 8'h00.
REQ-031 wrapFlag SHALL set on an advance that selects pcNextSeq while pcOut=8'hFF, and SHALL clear only on reset.
REQ-032 A jump or branch to 8'h00 SHALL NOT set wrapFlag.

Reset
REQ-033 When resetN=0 at a rising edge, the block SHALL load pcOut=RESET_PC, state=RUN, halted=0, retireCount=0 and wrapFlag=0.
REQ-034 Reset SHALL override every other input, including a mid-STEP or mid-stall condition.
REQ-035 There SHALL be no asynchronous reset path.

Verification
REQ-036 Run with resetN low for 2 cycles, then high, pcNextSeq=pcOut+1, 5 cycles, no other inputs -> pcOut 00,01,02,03,04,05; retireCount=5; halted=0.
REQ-037 At pcOut=8'h10, assert jump=1 (jumpTarget=8'h40), branchTaken=1 (branchTarget=8'h20) and stall=0 -> next pcOut=8'h40; repeat with stall=1 -> pcOut stays 8'h10 and retireCount is unchanged.
REQ-038 Assert haltReq with branchTaken=1 at pcOut=8'h05 -> pcOut stays 8'h05 and halted=1 the next cycle; stepReq pulse with stall high for 2 cycles -> PC held during the stall, then pcOut=8'h06 and halted=1 again; resumeReq+stepReq together -> RUN.
REQ-039 Sequential advance from pcOut=8'hFF -> pcOut=8'h00 and wrapFlag=1, persisting through later jumps; jump from 8'hFF to 8'h00 after reset -> wrapFlag=0.
REQ-040 Preload via 65 540 advances with COUNT_W=16 -> retireCount holds 16'hFFFF; resetN low mid-STEP -> pcOut=RESET_PC, state RUN, retireCount=0 the next cycle.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with RUN / HALTED / STEP debug control, a saturating
// retired-instruction counter and a sticky sequential-wrap flag.
module pc_sequencer #(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               resetN,
  output logic [7:0]         pcOut,
  input  logic [7:0]         pcNextSeq,
  input  logic [7:0]         branchTarget,
  input  logic               branchTaken,
  input  logic               jump,
  input  logic [7:0]         jumpTarget,
  input  logic               stall,
  input  logic               haltReq,
  input  logic               stepReq,
  input  logic               resumeReq,
  output logic               halted,
  output logic [COUNT_W-1:0] retireCount,
  output logic               wrapFlag
);

  localparam logic [COUNT_W-1:0] CountOne = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CountMax = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {StRun, StHalted, StStep} state_e;

  state_e             state_q, state_d;
  logic [7:0]         pc_q, pc_d;
  logic [COUNT_W-1:0] count_q;
  logic               halted_q;
  logic               wrap_q;
  logic               advance;
  logic               seq_sel;

  always_comb begin
    advance = 1'b0;
    state_d = state_q;
    case (state_q)
      StRun: begin
        // A halt request steals the cycle even when a branch or jump is pending.
        advance = ~haltReq & ~stall;
        if (haltReq) state_d = StHalted;
      end
      StHalted: begin
        if (resumeReq)    state_d = StRun;
        else if (stepReq) state_d = StStep;
      end
      StStep: begin
        advance = ~stall;
        if (!stall) state_d = StHalted;
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    seq_sel = 1'b0;
    if (jump)             pc_d = jumpTarget;
    else if (branchTaken) pc_d = branchTarget;
    else begin
      pc_d    = pcNextSeq;
      seq_sel = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q  <= StRun;
      pc_q     <= RESET_PC;
      count_q  <= '0;
      halted_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == StHalted);
      if (advance) begin
        pc_q <= pc_d;
        if (count_q != CountMax) count_q <= count_q + CountOne;
        // Only a sequential step off the top of memory counts as a wrap.
        if (seq_sel && (pc_q == 8'hFF)) wrap_q <= 1'b1;
      end
    end
  end

  assign pcOut       = pc_q;
  assign halted      = halted_q;
  assign retireCount = count_q;
  assign wrapFlag    = wrap_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer against a behavioural model.
module tb_pc_sequencer;

  localparam logic [7:0] ResetPc = 8'h00;

  logic        clk = 1'b0;
  logic        resetN;
  logic [7:0]  pcOut, pcNextSeq, branchTarget, jumpTarget;
  logic        branchTaken, jump, stall, haltReq, stepReq, resumeReq;
  logic        halted, wrapFlag;
  logic [15:0] retireCount;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: mode 0 = RUN, 1 = HALTED, 2 = STEP.
  int m_pc, m_mode, m_cnt;
  bit m_wrap;

  always #5 clk = ~clk;

  // External sequential adder.
  assign pcNextSeq = pcOut + 8'd1;

  pc_sequencer #(.RESET_PC(ResetPc), .COUNT_W(16)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .pcOut        (pcOut),
    .pcNextSeq    (pcNextSeq),
    .branchTarget (branchTarget),
    .branchTaken  (branchTaken),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .stall        (stall),
    .haltReq      (haltReq),
    .stepReq      (stepReq),
    .resumeReq    (resumeReq),
    .halted       (halted),
    .retireCount  (retireCount),
    .wrapFlag     (wrapFlag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic idle();
    resetN = 1'b1; branchTaken = 1'b0; jump = 1'b0; stall = 1'b0;
    haltReq = 1'b0; stepReq = 1'b0; resumeReq = 1'b0;
    branchTarget = 8'h00; jumpTarget = 8'h00;
  endtask

  // Apply current inputs for one clock, advance the model, optionally compare.
  task automatic cycle(input string tag, input bit chk);
    bit adv;
    if (!resetN) begin
      m_pc = ResetPc; m_mode = 0; m_cnt = 0; m_wrap = 1'b0;
    end else begin
      adv = (m_mode == 0 && !haltReq && !stall) || (m_mode == 2 && !stall);
      if (adv) begin
        if (!jump && !branchTaken && m_pc == 255) m_wrap = 1'b1;
        if (jump)             m_pc = jumpTarget;
        else if (branchTaken) m_pc = branchTarget;
        else                  m_pc = (m_pc + 1) % 256;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      case (m_mode)
        0: if (haltReq) m_mode = 1;
        1: if (resumeReq) m_mode = 0; else if (stepReq) m_mode = 2;
        default: if (!stall) m_mode = 1;
      endcase
    end
    @(posedge clk);
    #1;
    if (chk) begin
      check({tag, ".pc"},     32'(pcOut),       32'(m_pc));
      check({tag, ".halted"}, 32'(halted),      32'(m_mode == 1));
      check({tag, ".count"},  32'(retireCount), 32'(m_cnt));
      check({tag, ".wrap"},   32'(wrapFlag),    32'(m_wrap));
    end
  endtask

  task automatic do_jump(input logic [7:0] tgt, input string tag);
    idle(); jump = 1'b1; jumpTarget = tgt;
    cycle(tag, 1'b1);
    idle();
  endtask

  initial begin
    idle();
    m_pc = 0; m_mode = 0; m_cnt = 0; m_wrap = 1'b0;

    // Reset for two cycles, then five free-running advances.
    resetN = 1'b0;
    cycle("rst0", 1'b1);
    cycle("rst1", 1'b1);
    check("rst.pc_lit", 32'(pcOut), 32'h00);
    idle();
    for (int i = 0; i < 5; i++) cycle("seq", 1'b1);
    check("seq.pc_lit", 32'(pcOut), 32'h05);
    check("seq.cnt_lit", 32'(retireCount), 32'd5);

    // Jump beats branch; stall blocks both.
    do_jump(8'h10, "to10");
    jump = 1'b1; jumpTarget = 8'h40; branchTaken = 1'b1; branchTarget = 8'h20;
    cycle("prio", 1'b1);
    check("prio.pc_lit", 32'(pcOut), 32'h40);
    do_jump(8'h10, "to10b");
    jump = 1'b1; jumpTarget = 8'h40; branchTaken = 1'b1; branchTarget = 8'h20; stall = 1'b1;
    cycle("stallpr", 1'b1);
    check("stall.pc_lit", 32'(pcOut), 32'h10);
    idle();

    // Halt beats branch, stalled single step, then resume wins over step.
    do_jump(8'h05, "to05");
    haltReq = 1'b1; branchTaken = 1'b1; branchTarget = 8'h77;
    cycle("halt", 1'b1);
    check("halt.pc_lit", 32'(pcOut), 32'h05);
    idle(); stepReq = 1'b1; stall = 1'b1;
    cycle("stepgo", 1'b1);
    idle(); stall = 1'b1;
    cycle("stepst1", 1'b1);
    cycle("stepst2", 1'b1);
    idle(); haltReq = 1'b1; stepReq = 1'b1;
    cycle("stepdone", 1'b1);
    check("step.pc_lit", 32'(pcOut), 32'h06);
    check("step.halted_lit", 32'(halted), 32'd1);
    idle(); resumeReq = 1'b1; stepReq = 1'b1;
    cycle("resume", 1'b1);
    check("resume.halted_lit", 32'(halted), 32'd0);
    idle();
    cycle("runagain", 1'b1);

    // Sequential wrap sets the sticky flag; a jump to zero does not.
    do_jump(8'hFF, "toFF");
    cycle("wrap", 1'b1);
    check("wrap.flag_lit", 32'(wrapFlag), 32'd1);
    do_jump(8'h33, "postwrap");
    resetN = 1'b0;
    cycle("rst2", 1'b1);
    idle();
    do_jump(8'hFF, "toFF2");
    do_jump(8'h00, "jmp00");
    check("jmp00.flag_lit", 32'(wrapFlag), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      resetN       = ($urandom_range(0, 59) != 0);
      stall        = ($urandom_range(0, 3) == 0);
      jump         = ($urandom_range(0, 5) == 0);
      branchTaken  = ($urandom_range(0, 3) == 0);
      haltReq      = ($urandom_range(0, 7) == 0);
      stepReq      = ($urandom_range(0, 2) == 0);
      resumeReq    = ($urandom_range(0, 3) == 0);
      jumpTarget   = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
      branchTarget = 8'($urandom);
      cycle("rand", 1'b1);
    end

    // Saturate the counter, then reset from the middle of a stalled step.
    idle();
    resetN = 1'b0;
    cycle("rst3", 1'b1);
    idle();
    for (int i = 0; i < 65540; i++) cycle("preload", 1'b0);
    cycle("sat", 1'b1);
    check("sat.cnt_lit", 32'(retireCount), 32'h0000FFFF);
    haltReq = 1'b1;
    cycle("sathalt", 1'b1);
    idle(); stepReq = 1'b1; stall = 1'b1;
    cycle("satstep", 1'b1);
    idle(); stall = 1'b1; resetN = 1'b0;
    cycle("midstep_rst", 1'b1);
    check("midrst.pc_lit", 32'(pcOut), 32'(ResetPc));
    check("midrst.cnt_lit", 32'(retireCount), 32'd0);
    idle();
    cycle("postrst_run", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
